// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller:
// FSM states, opcode/funct values, ALU codes and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX,
    ALUWB, ADDI_EX, BEQ, JMP, JAL, JR, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MEM    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [4:0] alu_control;
    logic       halted;
  } ctrl_t;

  // Moore output table; rtype_alu and dst_rt carry the decoded funct and the
  // addi/R-type writeback destination into the states that need them.
  function automatic ctrl_t ctrl_for(state_t s, logic [4:0] rtype_alu, logic dst_rt);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (s)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_src    = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      DECODE:   c.alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMRD:    c.i_or_d = 1'b1;
      MEMWB: begin
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_MEM;
        c.reg_write  = 1'b1;
      end
      MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      RTYPE_EX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_control = rtype_alu;
      end
      ALUWB: begin
        c.reg_dst    = dst_rt ? DST_RT : DST_RD;
        c.mem_to_reg = M2R_ALUOUT;
        c.reg_write  = 1'b1;
      end
      BEQ: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_control = ALU_SUB;
        c.pc_src      = PCSRC_ALUOUT;
        c.branch      = 1'b1;
      end
      JMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      JR: begin
        c.pc_src   = PCSRC_REG;
        c.pc_write = 1'b1;
      end
      JAL: begin
        c.pc_src     = PCSRC_JUMP;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = M2R_PC;
      end
      HALT:     c.halted = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU operation decode; flags any funct the ALU cannot execute.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      F_ADD:   alu_control = ALU_ADD;
      F_SUB:   alu_control = ALU_SUB;
      F_AND:   alu_control = ALU_AND;
      F_OR:    alu_control = ALU_OR;
      F_SLT:   alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS-subset datapath, with a retired
// instruction counter and a sticky halt on illegal opcode/funct.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int RETIRE_W = 32,
  parameter int ALU_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pcEn,
  output logic                irWrite,
  output logic                iOrD,
  output logic                memWrite,
  output logic                regWrite,
  output logic [1:0]          regDst,
  output logic [1:0]          memToReg,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          pcSrc,
  output logic [ALU_W-1:0]    aluControl,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired,
  output state_t              state
);

  state_t                state_q, state_d;
  ctrl_t                 ctrl_q;
  logic                  dst_rt_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic [4:0]            dec_alu;
  logic                  dec_illegal;
  logic                  terminal;

  mc_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  assign terminal = state_q inside {MEMWB, MEMWR, ALUWB, BEQ, JMP, JR, JAL};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = run ? FETCH : IDLE;
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = (funct == F_JR) ? JR : RTYPE_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JMP;
          OP_JAL:       state_d = JAL;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      RTYPE_EX: state_d = dec_illegal ? HALT : ALUWB;
      ADDI_EX:  state_d = ALUWB;
      MEMWB, MEMWR, ALUWB, BEQ, JMP, JR, JAL:
                state_d = run ? FETCH : IDLE;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop per state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ctrl_q    <= ctrl_for(IDLE, ALU_ADD, 1'b0);
      dst_rt_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, dec_alu, dst_rt_q);
      if (state_q == DECODE) dst_rt_q <= (opcode == OP_ADDI);
      if (terminal) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign pcEn       = ctrl_q.pc_write | (ctrl_q.branch & zero);
  assign irWrite    = ctrl_q.ir_write;
  assign iOrD       = ctrl_q.i_or_d;
  assign memWrite   = ctrl_q.mem_write;
  assign regWrite   = ctrl_q.reg_write;
  assign regDst     = ctrl_q.reg_dst;
  assign memToReg   = ctrl_q.mem_to_reg;
  assign aluSrcA    = ctrl_q.alu_src_a;
  assign aluSrcB    = ctrl_q.alu_src_b;
  assign pcSrc      = ctrl_q.pc_src;
  assign aluControl = ALU_W'(ctrl_q.alu_control);
  assign halted     = ctrl_q.halted;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;
  import mc_pkg::*;

  localparam int VW = 56;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        pcEn, irWrite, iOrD, memWrite, regWrite, aluSrcA, halted;
  logic [1:0]  regDst, memToReg, aluSrcB, pcSrc;
  logic [4:0]  aluControl;
  logic [31:0] retired;
  state_t      state;

  int checks = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mask_q[$];
  string         name_q[$];

  logic [31:0] exp_ret = '0;
  logic [4:0]  rt_alu = ALU_ADD;
  logic        rt_known = 1'b1;
  logic [1:0]  wb_dst = 2'd1;

  multicycle_control #(.RETIRE_W(32), .ALU_W(5)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .pcEn(pcEn), .irWrite(irWrite), .iOrD(iOrD),
    .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
    .aluControl(aluControl), .halted(halted), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  // Expected outputs per state, written out from the control table by hand.
  function automatic logic [VW-1:0] model(state_t st, logic z, logic [31:0] ret);
    logic       pcen, irw, iord, memw, regw, srca, halt;
    logic [1:0] rd, m2r, srcb, pcs;
    logic [4:0] alu;
    {pcen, irw, iord, memw, regw, srca, halt} = '0;
    {rd, m2r, srcb, pcs} = '0;
    alu = 5'b00010;
    case (st)
      FETCH:    begin irw = 1; pcen = 1; srcb = 2'd1; end
      DECODE:   srcb = 2'd3;
      MEMADR:   begin srca = 1; srcb = 2'd2; end
      MEMRD:    iord = 1;
      MEMWB:    begin regw = 1; m2r = 2'd1; end
      MEMWR:    begin iord = 1; memw = 1; end
      RTYPE_EX: begin srca = 1; alu = rt_alu; end
      ALUWB:    begin regw = 1; rd = wb_dst; end
      ADDI_EX:  begin srca = 1; srcb = 2'd2; end
      BEQ:      begin srca = 1; alu = 5'b00110; pcs = 2'd1; pcen = z; end
      JMP:      begin pcs = 2'd2; pcen = 1; end
      JR:       begin pcs = 2'd3; pcen = 1; end
      JAL:      begin pcs = 2'd2; pcen = 1; regw = 1; rd = 2'd2; m2r = 2'd2; end
      HALT:     halt = 1;
      default:  ;
    endcase
    return {st, pcen, irw, iord, memw, regw, rd, m2r, srca, srcb, pcs, alu, halt, ret};
  endfunction

  function automatic logic alu_meaningful(state_t st);
    if (st inside {FETCH, DECODE, MEMADR, ADDI_EX, BEQ}) return 1'b1;
    if (st == RTYPE_EX) return rt_known;
    return 1'b0;
  endfunction

  task automatic cyc(input state_t st, input string nm);
    logic [VW-1:0] m;
    @(posedge clock);
    m = '1;
    if (!(alu_meaningful(st) || reset)) m[37:33] = '0;
    exp_q.push_back(model(st, zero, exp_ret));
    mask_q.push_back(m);
    name_q.push_back(nm);
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [VW-1:0] obs, e, m;
    string n;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        n = name_q.pop_front();
        obs = {state, pcEn, irWrite, iOrD, memWrite, regWrite, regDst, memToReg,
               aluSrcA, aluSrcB, pcSrc, aluControl, halted, retired};
        checks++;
        if ((obs & m) !== (e & m)) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", n, obs & m, e & m);
        end
      end
    end
  end

  initial begin
    repeat (3) cyc(IDLE, "reset_idle");
    reset = 0;
    cyc(IDLE, "parked_idle");
    run = 1; opcode = OP_LW;
    cyc(FETCH, "lw_fetch"); cyc(DECODE, "lw_decode"); cyc(MEMADR, "lw_memadr");
    cyc(MEMRD, "lw_memrd"); cyc(MEMWB, "lw_memwb"); exp_ret = 1;
    opcode = OP_BEQ; zero = 1;
    cyc(FETCH, "beq1_fetch"); cyc(DECODE, "beq1_decode"); cyc(BEQ, "beq_taken");
    exp_ret = 2; zero = 0;
    cyc(FETCH, "beq2_fetch"); cyc(DECODE, "beq2_decode"); cyc(BEQ, "beq_not_taken");
    exp_ret = 3; opcode = OP_JAL;
    cyc(FETCH, "jal_fetch"); cyc(DECODE, "jal_decode"); cyc(JAL, "jal");
    exp_ret = 4; opcode = OP_ADDI; wb_dst = 2'd0;
    cyc(FETCH, "addi_fetch"); cyc(DECODE, "addi_decode"); cyc(ADDI_EX, "addi_ex");
    cyc(ALUWB, "addi_wb");
    exp_ret = 5; opcode = OP_RTYPE; funct = F_SUB; rt_alu = ALU_SUB; wb_dst = 2'd1;
    cyc(FETCH, "sub_fetch"); cyc(DECODE, "sub_decode"); cyc(RTYPE_EX, "sub_ex");
    cyc(ALUWB, "sub_wb");
    exp_ret = 6; funct = F_SLT; rt_alu = ALU_SLT;
    cyc(FETCH, "slt_fetch"); cyc(DECODE, "slt_decode"); cyc(RTYPE_EX, "slt_ex");
    cyc(ALUWB, "slt_wb");
    exp_ret = 7; opcode = OP_SW;
    cyc(FETCH, "sw_fetch"); cyc(DECODE, "sw_decode");
    run = 0;
    cyc(MEMADR, "sw_memadr_run_low"); cyc(MEMWR, "sw_memwr");
    exp_ret = 8;
    cyc(IDLE, "sw_then_idle");
    run = 1; opcode = OP_RTYPE; funct = F_JR;
    cyc(FETCH, "jr_fetch"); cyc(DECODE, "jr_decode"); cyc(JR, "jr");
    exp_ret = 9; opcode = OP_J;
    cyc(FETCH, "j_fetch"); cyc(DECODE, "j_decode"); cyc(JMP, "j");
    exp_ret = 10; opcode = OP_RTYPE; funct = 6'b111111; rt_known = 0;
    cyc(FETCH, "badf_fetch"); cyc(DECODE, "badf_decode"); cyc(RTYPE_EX, "badf_ex");
    for (int i = 0; i < 11; i++) cyc(HALT, "halt_frozen");
    rt_known = 1; reset = 1; exp_ret = 0;
    cyc(IDLE, "halt_reset");
    reset = 0; opcode = 6'b111111;
    cyc(FETCH, "badop_fetch"); cyc(DECODE, "badop_decode"); cyc(HALT, "badop_halt");
    reset = 1;
    cyc(IDLE, "badop_reset");
    reset = 0; opcode = OP_LW;
    cyc(FETCH, "lw2_fetch"); cyc(DECODE, "lw2_decode"); cyc(MEMADR, "lw2_memadr");
    cyc(MEMRD, "lw2_memrd");
    reset = 1;
    cyc(IDLE, "reset_mid_lw");
    reset = 0; run = 0;
    cyc(IDLE, "after_mid_reset"); cyc(IDLE, "still_idle");
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
